// File: rtl/cordic_l_ctrl_pkg.sv
// Shared types and select encodings for the CORDIC_L control FSM.
// Optional feature macro: CORDIC_CTRL_TIMEOUT_EN (FPU ack timeout).
package cordic_l_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_INIT_X, ST_INIT_Y, ST_SHIFT, ST_IT_X, ST_IT_Y,
    ST_IT_Z, ST_NEXT, ST_FINAL, ST_RWND, ST_RWND_P, ST_DONE, ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    SQ_IDLE, SQ_SEL, SQ_SUM, SQ_WAIT, SQ_STORE
  } seq_t;

  localparam logic [1:0] MS2_Z     = 2'd0;
  localparam logic [1:0] MS2_Y     = 2'd1;
  localparam logic [1:0] MS2_X     = 2'd2;
  localparam logic [1:0] MS3_REG2Z = 2'd0;
  localparam logic [1:0] MS3_REG2Y = 2'd1;
  localparam logic [1:0] MS3_REG2X = 2'd2;
  localparam logic [1:0] MS4_LN    = 2'd0;
  localparam logic [1:0] MS4_ITER  = 2'd1;
  localparam logic [1:0] MS4_INIT  = 2'd2;
  localparam logic       OP_ADD    = 1'b0;
  localparam logic       OP_SUB    = 1'b1;

  // States that own one shared-adder operation.
  function automatic logic is_op(state_t s);
    return (s == ST_INIT_X) || (s == ST_INIT_Y) || (s == ST_IT_X) ||
           (s == ST_IT_Y) || (s == ST_IT_Z) || (s == ST_FINAL);
  endfunction

endpackage

// File: rtl/cordic_l_ctrl_fsm_fpu_op_seq.sv
// One FP adder operation: SEL -> SUM -> WAIT -> STORE.
// With CORDIC_CTRL_TIMEOUT_EN a stalled WAIT raises tmo after TO_CYC cycles.
module fpu_op_seq
  import cordic_l_ctrl_pkg::*;
`ifdef CORDIC_CTRL_TIMEOUT_EN
  #(parameter int TO_CYC = 64)
`endif
(
  input  logic CLK,
  input  logic RST,
`ifdef CORDIC_CTRL_TIMEOUT_EN
  output logic tmo,
`endif
  input  logic go,
  input  logic ACK_SUM,
  output logic EN_REG2XYZ,
  output logic Begin_SUM,
  output logic store,
  output logic done
);

  seq_t sst, snxt;

  // Result accepted this cycle; STORE follows on the next edge.
  assign done = (sst == SQ_WAIT) && ACK_SUM;

`ifdef CORDIC_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] cnt;

  assign tmo = (sst == SQ_WAIT) && !ACK_SUM && (cnt == TW'(TO_CYC - 1));

  // Cycles spent in WAIT; held at zero everywhere else so entry starts at 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                 cnt <= '0;
    else if (sst != SQ_WAIT)  cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end
`endif

  // Next sequencer state; ACK_SUM only matters in WAIT.
  always_comb begin
    snxt = sst;
    case (sst)
      SQ_IDLE:  if (go) snxt = SQ_SEL;
      SQ_SEL:   snxt = SQ_SUM;
      SQ_SUM:   snxt = SQ_WAIT;
      SQ_WAIT:  if (ACK_SUM) snxt = SQ_STORE;
      SQ_STORE: snxt = go ? SQ_SEL : SQ_IDLE;
      default:  snxt = SQ_IDLE;
    endcase
`ifdef CORDIC_CTRL_TIMEOUT_EN
    if (tmo) snxt = SQ_IDLE;
`endif
  end

  // State plus registered Moore strobes decoded from the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sst        <= SQ_IDLE;
      EN_REG2XYZ <= 1'b0;
      Begin_SUM  <= 1'b0;
      store      <= 1'b0;
    end else begin
      sst        <= snxt;
      EN_REG2XYZ <= (snxt == SQ_SEL);
      Begin_SUM  <= (snxt == SQ_SUM);
      store      <= (snxt == SQ_STORE);
    end
  end

endmodule

// File: rtl/cordic_l_ctrl_fsm.sv
// Control FSM for the CORDIC_L hyperbolic-vectoring datapath.
// Optional feature macro: CORDIC_CTRL_TIMEOUT_EN (ERR on FPU ack timeout).
module cordic_l_ctrl_fsm
  import cordic_l_ctrl_pkg::*;
#(
  parameter int D    = 5,
  parameter int ITER = 16
`ifdef CORDIC_CTRL_TIMEOUT_EN
  , parameter int TO_CYC = 64
`endif
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BEG_FSM_CORDIC,
  input  logic         ACK_SUM,
  input  logic         SIGN_Y,
  input  logic [D-1:0] CONT_ITERA,
  output logic         MS_1,
  output logic         EN_REG3,
  output logic         EN_REG1X,
  output logic         EN_REG1Y,
  output logic         EN_REG1Z,
  output logic [1:0]   MS_2,
  output logic         EN_REG2XYZ,
  output logic         EN_REG2,
  output logic [1:0]   MS_3,
  output logic [1:0]   MS_4,
  output logic         ADD_SUBT,
  output logic         Begin_SUM,
  output logic         CLK_CDIR,
  output logic         EN_REG4,
  output logic         ACK_FSM_CORDIC,
  output logic         ERR
);

  // Pre-increment counter value seen in NEXT of the last iteration.
  localparam logic [D-1:0] LAST = D'(ITER - 1);

  state_t     state, nxt;
  logic       sgn_q, sgn_eff, go, store, done;
  logic [1:0] ms2_n, ms3_n, ms4_n;
  logic       as_n;

  // Direction bit: SIGN_Y is live only in SHIFT, then frozen for the iteration.
  assign sgn_eff = (state == ST_SHIFT) ? SIGN_Y : sgn_q;
  assign go      = is_op(nxt) && (nxt != state);

`ifdef CORDIC_CTRL_TIMEOUT_EN
  logic tmo;
  fpu_op_seq #(.TO_CYC(TO_CYC)) u_seq (
    .CLK(CLK), .RST(RST), .tmo(tmo), .go(go), .ACK_SUM(ACK_SUM),
    .EN_REG2XYZ(EN_REG2XYZ), .Begin_SUM(Begin_SUM), .store(store), .done(done)
  );
`else
  fpu_op_seq u_seq (
    .CLK(CLK), .RST(RST), .go(go), .ACK_SUM(ACK_SUM),
    .EN_REG2XYZ(EN_REG2XYZ), .Begin_SUM(Begin_SUM), .store(store), .done(done)
  );
`endif

  // Run flow; op states are left on the sequencer's STORE cycle.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (BEG_FSM_CORDIC) nxt = ST_LOAD;
      ST_LOAD:   nxt = ST_INIT_X;
      ST_INIT_X: if (store) nxt = ST_INIT_Y;
      ST_INIT_Y: if (store) nxt = ST_SHIFT;
      ST_SHIFT:  nxt = ST_IT_X;
      ST_IT_X:   if (store) nxt = ST_IT_Y;
      ST_IT_Y:   if (store) nxt = ST_IT_Z;
      ST_IT_Z:   if (store) nxt = ST_NEXT;
      ST_NEXT:   nxt = (CONT_ITERA == LAST) ? ST_FINAL : ST_SHIFT;
      ST_FINAL:  if (store) nxt = ST_RWND;
      ST_RWND:   nxt = (CONT_ITERA == '0) ? ST_DONE : ST_RWND_P;
      ST_RWND_P: nxt = ST_RWND;
      ST_DONE:   if (!BEG_FSM_CORDIC) nxt = ST_IDLE;
      ST_ERROR:  nxt = ST_ERROR;
      default:   nxt = ST_IDLE;
    endcase
`ifdef CORDIC_CTRL_TIMEOUT_EN
    if (tmo) nxt = ST_ERROR;
`endif
  end

  // Operand/op selects for the op being entered or held.
  always_comb begin
    ms2_n = MS2_Z;
    ms3_n = MS3_REG2Z;
    ms4_n = MS4_LN;
    as_n  = OP_ADD;
    case (nxt)
      ST_INIT_X: ms4_n = MS4_INIT;
      ST_INIT_Y: begin ms4_n = MS4_INIT; as_n = OP_SUB; end
      ST_IT_X:   begin ms2_n = MS2_X; ms3_n = MS3_REG2X; ms4_n = MS4_ITER; as_n = ~sgn_eff; end
      ST_IT_Y:   begin ms2_n = MS2_Y; ms3_n = MS3_REG2Y; ms4_n = MS4_ITER; as_n = ~sgn_eff; end
      ST_IT_Z:   begin ms4_n = MS4_ITER; as_n = sgn_eff; end
      ST_FINAL:  as_n = OP_SUB;
      default:   ;
    endcase
  end

  // State and registered outputs; store enables fire as the sequencer enters STORE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= ST_IDLE;
      sgn_q          <= 1'b0;
      MS_1           <= 1'b0;
      EN_REG3        <= 1'b0;
      EN_REG1X       <= 1'b0;
      EN_REG1Y       <= 1'b0;
      EN_REG1Z       <= 1'b0;
      MS_2           <= MS2_Z;
      EN_REG2        <= 1'b0;
      MS_3           <= MS3_REG2Z;
      MS_4           <= MS4_LN;
      ADD_SUBT       <= OP_ADD;
      CLK_CDIR       <= 1'b0;
      EN_REG4        <= 1'b0;
      ACK_FSM_CORDIC <= 1'b0;
    end else begin
      state          <= nxt;
      if (state == ST_SHIFT) sgn_q <= SIGN_Y;
      MS_1           <= (nxt == ST_LOAD);
      EN_REG3        <= (nxt == ST_LOAD);
      EN_REG1X       <= done && ((state == ST_INIT_X) || (state == ST_IT_X));
      EN_REG1Y       <= done && ((state == ST_INIT_Y) || (state == ST_IT_Y));
      EN_REG1Z       <= (nxt == ST_LOAD) || (done && (state == ST_IT_Z));
      MS_2           <= ms2_n;
      EN_REG2        <= (nxt == ST_SHIFT);
      MS_3           <= ms3_n;
      MS_4           <= ms4_n;
      ADD_SUBT       <= as_n;
      CLK_CDIR       <= (nxt == ST_NEXT) || (nxt == ST_RWND_P);
      EN_REG4        <= done && (state == ST_FINAL);
      ACK_FSM_CORDIC <= (nxt == ST_DONE);
    end
  end

`ifdef CORDIC_CTRL_TIMEOUT_EN
  // Sticky error flag; only reset leaves ERROR.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ERR <= 1'b0;
    else      ERR <= (nxt == ST_ERROR);
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_l_ctrl_fsm.sv
// Directed bench for cordic_l_ctrl_fsm (default ITER=16 and an ITER=32 copy).
// Timeout checks are active when CORDIC_CTRL_TIMEOUT_EN is defined.
module tb_cordic_l_ctrl_fsm;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       beg = 1'b0, ack_sum = 1'b0, sign_y = 1'b0;
  logic [4:0] cont = '0;
  logic       ms_1, en_reg3, en_reg1x, en_reg1y, en_reg1z, en_reg2xyz, en_reg2;
  logic [1:0] ms_2, ms_3, ms_4;
  logic       add_subt, begin_sum, clk_cdir, en_reg4, ack_fsm, err;
  logic [18:0] outs;

  assign outs = {ms_1, en_reg3, en_reg1x, en_reg1y, en_reg1z, ms_2, en_reg2xyz, en_reg2,
                 ms_3, ms_4, add_subt, begin_sum, clk_cdir, en_reg4, ack_fsm, err};

  cordic_l_ctrl_fsm u_dut (
    .CLK(clk), .RST(rst_n), .BEG_FSM_CORDIC(beg), .ACK_SUM(ack_sum), .SIGN_Y(sign_y),
    .CONT_ITERA(cont), .MS_1(ms_1), .EN_REG3(en_reg3), .EN_REG1X(en_reg1x),
    .EN_REG1Y(en_reg1y), .EN_REG1Z(en_reg1z), .MS_2(ms_2), .EN_REG2XYZ(en_reg2xyz),
    .EN_REG2(en_reg2), .MS_3(ms_3), .MS_4(ms_4), .ADD_SUBT(add_subt),
    .Begin_SUM(begin_sum), .CLK_CDIR(clk_cdir), .EN_REG4(en_reg4),
    .ACK_FSM_CORDIC(ack_fsm), .ERR(err)
  );

  // ITER = 2**D copy: ACK_SUM tied high, SIGN_Y fixed.
  logic       beg2 = 1'b0, ack2 = 1'b1, sgn2 = 1'b0;
  logic [4:0] cont2 = '0;
  logic       b_ms1, b_r3, b_r1x, b_r1y, b_r1z, b_r2xyz, b_r2, b_as, b_bs, b_cd, b_r4, b_ack, b_err;
  logic [1:0] b_ms2, b_ms3, b_ms4;

  cordic_l_ctrl_fsm #(.D(5), .ITER(32)) u_dut32 (
    .CLK(clk), .RST(rst_n), .BEG_FSM_CORDIC(beg2), .ACK_SUM(ack2), .SIGN_Y(sgn2),
    .CONT_ITERA(cont2), .MS_1(b_ms1), .EN_REG3(b_r3), .EN_REG1X(b_r1x),
    .EN_REG1Y(b_r1y), .EN_REG1Z(b_r1z), .MS_2(b_ms2), .EN_REG2XYZ(b_r2xyz),
    .EN_REG2(b_r2), .MS_3(b_ms3), .MS_4(b_ms4), .ADD_SUBT(b_as),
    .Begin_SUM(b_bs), .CLK_CDIR(b_cd), .EN_REG4(b_r4),
    .ACK_FSM_CORDIC(b_ack), .ERR(b_err)
  );

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Datapath/FPU model and pulse log, driven away from the rising edge.
  int          ack_mode = 0;   // 0: ack 3 cycles after Begin_SUM, 1: stuck high, 2: manual
  logic [2:0]  ap = '0;
  logic        cdir_d = 1'b0, cd2 = 1'b0;
  int          n_beg, n_cdir, n_r4, n_st, n_shift, n_cdir2 = 0, n_beg2 = 0;
  logic [6:0]  l_op [64];
  logic [1:0]  l_dst[64];
  logic        l_as [64];
  logic [31:0] pat = 32'hA5C3_96E1;

  initial forever begin
    @(negedge clk);
    if (cdir_d) cont = cont + 1'b1;
    cdir_d = clk_cdir;
    if (ack_mode == 0)      ack_sum = ap[2];
    else if (ack_mode == 1) ack_sum = 1'b1;
    ap = {ap[1:0], begin_sum};
    if (begin_sum) begin
      if (n_beg < 64) l_op[n_beg] = {ms_2, ms_3, ms_4, add_subt};
      n_beg++;
    end
    if (en_reg1x || en_reg1y || (en_reg1z && !en_reg3) || en_reg4) begin
      if (n_st < 64) begin
        l_dst[n_st] = en_reg1x ? 2'd0 : en_reg1y ? 2'd1 : en_reg1z ? 2'd2 : 2'd3;
        l_as[n_st]  = add_subt;
      end
      n_st++;
    end
    if (clk_cdir) n_cdir++;
    if (en_reg4)  n_r4++;
    if (en_reg2) begin sign_y = pat[n_shift % 32]; n_shift++; end
    else         sign_y = 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(negedge clk);
    if (cd2) cont2 = cont2 + 1'b1;
    cd2 = b_cd;
    if (b_cd) n_cdir2++;
    if (b_bs) n_beg2++;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clr;
    ap = '0; cdir_d = 1'b0;
    n_beg = 0; n_cdir = 0; n_r4 = 0; n_st = 0; n_shift = 0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (!ack_fsm && k < lim) begin tick; k++; end
    chk(tag, ack_fsm, 1);
  endtask

  task automatic run_counts(input string tag);
    chk({tag, "_beg"},  n_beg,  51);
    chk({tag, "_cdir"}, n_cdir, 32);
    chk({tag, "_r4"},   n_r4,   1);
    chk({tag, "_st"},   n_st,   51);
    chk({tag, "_cont"}, cont,   0);
  endtask

  // Expected {MS_2, MS_3, MS_4, ADD_SUBT} of op n, with per-iteration sign from p.
  function automatic logic [6:0] exp_op(input int n, input logic [31:0] p);
    logic s;
    if (n == 0)  return {2'd0, 2'd0, 2'd2, 1'b0};
    if (n == 1)  return {2'd0, 2'd0, 2'd2, 1'b1};
    if (n == 50) return {2'd0, 2'd0, 2'd0, 1'b1};
    s = p[(n - 2) / 3];
    case ((n - 2) % 3)
      0:       return {2'd2, 2'd2, 2'd1, ~s};
      1:       return {2'd1, 2'd1, 2'd1, ~s};
      default: return {2'd0, 2'd0, 2'd1, s};
    endcase
  endfunction

  function automatic logic [1:0] exp_dst(input int n);
    if (n == 0)  return 2'd0;
    if (n == 1)  return 2'd1;
    if (n == 50) return 2'd3;
    return 2'((n - 2) % 3);
  endfunction

  initial begin
    int   k;
    logic early;
    clr;
    repeat (3) tick;
    chk("rst_outs", outs, 0);
    rst_n = 1'b1;
    tick;
    chk("idle_outs", outs, 0);

    // Run A: auto ack, BEG held through DONE.
    beg = 1'b1;
    tick;
    chk("load", {ms_1, en_reg3, en_reg1z, en_reg1x}, 4'b1110);
    wait_done("a_done", 2000);
    run_counts("a");
    for (int n = 0; n < 51; n++) begin
      chk($sformatf("op%0d_sel", n), l_op[n], exp_op(n, pat));
      chk($sformatf("op%0d_dst", n), l_dst[n], exp_dst(n));
      chk($sformatf("op%0d_as", n),  l_as[n], exp_op(n, pat) & 7'h1);
    end
    repeat (20) tick;
    chk("a_hold_ack", ack_fsm, 1);
    chk("a_norestart", n_beg, 51);
    beg = 1'b0;
    tick;
    chk("a_ack_drop", ack_fsm, 0);

    // Run B: reassert, identical counts.
    clr; beg = 1'b1;
    wait_done("b_done", 2000);
    run_counts("b");
    beg = 1'b0; tick;

    // Reset in WAIT of the Y op of iteration 5 (op 18).
    clr; beg = 1'b1; k = 0;
    while (n_beg < 19 && k < 1000) begin tick; k++; end
    chk("rst_reach", n_beg, 19);
    chk("rst_in_y", ms_2, 1);
    rst_n = 1'b0; #1;
    chk("rst_async", outs, 0);
    tick;
    chk("rst_edge", outs, 0);
    beg = 1'b0; ack_sum = 1'b0; cont = '0; clr;
    rst_n = 1'b1;
    tick;
    chk("rst_idle", outs, 0);
    beg = 1'b1;
    wait_done("c_done", 2000);
    run_counts("c");
    beg = 1'b0; tick;

    // Handshake: ack in SUM ignored, real ack 6 cycles later stores once.
    clr; ack_mode = 2; ack_sum = 1'b0; beg = 1'b1; k = 0;
    while (!begin_sum && k < 50) begin tick; k++; end
    chk("hs_sum", begin_sum, 1);
    ack_sum = 1'b1; tick; ack_sum = 1'b0;
    early = 1'b0;
    repeat (5) begin early |= en_reg1x; tick; end
    early |= en_reg1x;
    ack_sum = 1'b1; tick; ack_sum = 1'b0;
    chk("hs_early", early, 0);
    chk("hs_store", en_reg1x, 1);
    k = 0;
    while (!begin_sum && k < 50) begin tick; k++; end
    chk("stall_sum", begin_sum, 1);
`ifdef CORDIC_CTRL_TIMEOUT_EN
    repeat (64) tick;
    chk("to_pre", err, 0);
    tick;
    chk("to_err", err, 1);
    chk("to_outs", outs[18:1], 0);
`else
    repeat (65) tick;
    chk("stall_err", err, 0);
    chk("stall_y", en_reg1y, 0);
`endif
    rst_n = 1'b0; tick;
    beg = 1'b0; cont = '0; clr; rst_n = 1'b1; tick;

    // ACK_SUM stuck high: one store per op.
    ack_mode = 1; beg = 1'b1;
    wait_done("stk_done", 2000);
    run_counts("stk");
    beg = 1'b0; tick; ack_mode = 0;

    // ITER = 2**D: no rewind pulses.
    n_cdir2 = 0; n_beg2 = 0; beg2 = 1'b1; k = 0;
    while (!b_ack && k < 3000) begin tick; k++; end
    chk("i32_done", b_ack, 1);
    chk("i32_cdir", n_cdir2, 32);
    chk("i32_beg", n_beg2, 99);
    chk("i32_cont", cont2, 0);
    beg2 = 1'b0; tick;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
